// File: rtl/perf_counter_bank_pkg.sv
// Shared definitions for the performance-counter bank: register map, control bit
// positions, standard pipeline event indices and the counter-address decoder.
package perf_counter_bank_pkg;

    localparam logic [7:0] ADDR_GCTRL    = 8'h00;
    localparam logic [7:0] ADDR_OVF      = 8'h01;
    localparam logic [7:0] ADDR_MASK     = 8'h02;
    localparam logic [7:0] ADDR_CNT_BASE = 8'h10;

    localparam int GCTRL_EN_BIT     = 0;
    localparam int GCTRL_FREEZE_BIT = 1;
    localparam int GCTRL_SNAP_BIT   = 2;
    localparam int GCTRL_CLEAR_BIT  = 3;

    localparam int CTRL_EN_BIT   = 8;
    localparam int CTRL_EDGE_BIT = 9;

    localparam int EVT_INST          = 0;
    localparam int EVT_LOAD          = 1;
    localparam int EVT_STORE         = 2;
    localparam int EVT_LOAD_WAITACK  = 3;
    localparam int EVT_STORE_WAITACK = 4;
    localparam int EVT_CYCLE         = 5;

    typedef enum logic [1:0] {
        REG_CTRL = 2'd0,
        REG_LO   = 2'd1,
        REG_HI   = 2'd2,
        REG_RSVD = 2'd3
    } cnt_reg_e;

    typedef struct packed {
        logic     hit;
        logic [5:0] idx;
        cnt_reg_e kind;
    } cnt_addr_t;

    // Each counter owns a 4-word window starting at ADDR_CNT_BASE.
    function automatic cnt_addr_t decode_cnt_addr(input logic [7:0] addr, input int num_cnt);
        cnt_addr_t d;
        d.idx  = addr[7:2] - 6'd4;
        d.kind = cnt_reg_e'(addr[1:0]);
        d.hit  = (addr >= ADDR_CNT_BASE) && (int'(d.idx) < num_cnt);
        return d;
    endfunction

endpackage

// File: rtl/perf_counter_slice.sv
// One programmable counter: event select, level/edge qualification, live count,
// snapshot shadow and wrap detection.
module perf_counter_slice
    import perf_counter_bank_pkg::*;
#(
    parameter int NUM_EVT   = 16,
    parameter int CNT_WIDTH = 48
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_EVT-1:0] evt,
    input  logic [NUM_EVT-1:0] evt_q,
    input  logic               count_ok,
    input  logic               clear_all,
    input  logic               snapshot,
    input  logic               ctrl_we,
    input  logic               lo_we,
    input  logic               hi_we,
    input  logic [31:0]        wdata,
    output logic [31:0]        ctrl_rd,
    output logic [31:0]        lo_rd,
    output logic [31:0]        hi_rd,
    output logic               ovf_set
);

    localparam int SEL_W = $clog2(NUM_EVT);

    logic [SEL_W-1:0]     sel;
    logic                 en;
    logic                 edge_mode;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] shadow;
    logic [CNT_WIDTH-1:0] cnt_loaded;
    logic [63:0]          cnt_ext;
    logic [63:0]          shadow_ext;
    logic                 cond;
    logic                 inc;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        cond = 1'b0;
        if (32'(sel) < 32'(NUM_EVT))
            cond = evt[sel] & ~(edge_mode & evt_q[sel]);
    end

    // A software load wins over the increment of the same cycle.
    assign inc     = count_ok & en & cond & ~lo_we & ~hi_we & ~clear_all;
    assign ovf_set = inc & (&cnt);

    // Widen to 64 bits so LO/HI loads work for any width from 32 to 64.
    always_comb begin
        cnt_ext = 64'(cnt);
        if (lo_we)
            cnt_ext[31:0] = wdata;
        if (hi_we)
            cnt_ext[63:32] = wdata;
        cnt_loaded = cnt_ext[CNT_WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sel       <= '0;
            en        <= 1'b0;
            edge_mode <= 1'b0;
            cnt       <= '0;
            shadow    <= '0;
        end else begin
            if (ctrl_we) begin
                sel       <= wdata[SEL_W-1:0];
                en        <= wdata[CTRL_EN_BIT];
                edge_mode <= wdata[CTRL_EDGE_BIT];
            end
            if (snapshot)
                shadow <= cnt;
            if (clear_all)
                cnt <= '0;
            else if (lo_we || hi_we)
                cnt <= cnt_loaded;
            else if (inc)
                cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        ctrl_rd                = '0;
        ctrl_rd[SEL_W-1:0]     = sel;
        ctrl_rd[CTRL_EN_BIT]   = en;
        ctrl_rd[CTRL_EDGE_BIT] = edge_mode;
    end

    assign shadow_ext = 64'(shadow);
    assign lo_rd      = shadow_ext[31:0];
    assign hi_rd      = shadow_ext[63:32];

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT programmable performance counters with global control,
// overflow flags, masked interrupt, atomic snapshot and a word-addressed config port.
module perf_counter_bank
    import perf_counter_bank_pkg::*;
#(
    parameter int NUM_CNT   = 8,
    parameter int NUM_EVT   = 16,
    parameter int CNT_WIDTH = 48
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               cfg_wen,
    input  logic               cfg_ren,
    input  logic [7:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               cfg_rvalid,
    output logic               irq_o
);

    logic               global_en;
    logic               freeze_on_ovf;
    logic [NUM_CNT-1:0] ovf;
    logic [NUM_CNT-1:0] mask;
    logic [NUM_CNT-1:0] ovf_set;
    logic [NUM_CNT-1:0] ovf_next;
    logic [NUM_CNT-1:0] mask_next;
    logic [NUM_EVT-1:0] evt_q;
    logic [31:0]        ctrl_rd [NUM_CNT];
    logic [31:0]        lo_rd   [NUM_CNT];
    logic [31:0]        hi_rd   [NUM_CNT];
    logic [31:0]        rd_mux;
    cnt_addr_t          ca;
    logic               gctrl_we;
    logic               ovf_we;
    logic               mask_we;
    logic               snapshot;
    logic               clear_all;
    logic               count_ok;

    assign ca        = decode_cnt_addr(cfg_addr, NUM_CNT);
    assign gctrl_we  = cfg_wen && (cfg_addr == ADDR_GCTRL);
    assign ovf_we    = cfg_wen && (cfg_addr == ADDR_OVF);
    assign mask_we   = cfg_wen && (cfg_addr == ADDR_MASK);
    assign snapshot  = gctrl_we & cfg_wdata[GCTRL_SNAP_BIT];
    assign clear_all = gctrl_we & cfg_wdata[GCTRL_CLEAR_BIT];
    assign count_ok  = global_en & ~(freeze_on_ovf & (|ovf));

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        logic win_we;
        assign win_we = cfg_wen & ca.hit & (ca.idx == 6'(i));

        perf_counter_slice #(
            .NUM_EVT   (NUM_EVT),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_slice (
            .clk       (clk),
            .resetn    (resetn),
            .evt       (evt_i),
            .evt_q     (evt_q),
            .count_ok  (count_ok),
            .clear_all (clear_all),
            .snapshot  (snapshot),
            .ctrl_we   (win_we & (ca.kind == REG_CTRL)),
            .lo_we     (win_we & (ca.kind == REG_LO)),
            .hi_we     (win_we & (ca.kind == REG_HI)),
            .wdata     (cfg_wdata),
            .ctrl_rd   (ctrl_rd[i]),
            .lo_rd     (lo_rd[i]),
            .hi_rd     (hi_rd[i]),
            .ovf_set   (ovf_set[i])
        );
    end

    // A fresh overflow beats a same-cycle W1C; clear_all beats both.
    always_comb begin
        ovf_next = ovf;
        if (ovf_we)
            ovf_next = ovf & ~cfg_wdata[NUM_CNT-1:0];
        ovf_next = ovf_next | ovf_set;
        if (clear_all)
            ovf_next = '0;
        mask_next = mask_we ? cfg_wdata[NUM_CNT-1:0] : mask;
    end

    always_comb begin
        rd_mux = '0;
        case (cfg_addr)
            ADDR_GCTRL: rd_mux[GCTRL_FREEZE_BIT:GCTRL_EN_BIT] = {freeze_on_ovf, global_en};
            ADDR_OVF:   rd_mux[NUM_CNT-1:0] = ovf;
            ADDR_MASK:  rd_mux[NUM_CNT-1:0] = mask;
            default: begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if (ca.hit && (ca.idx == 6'(i))) begin
                        case (ca.kind)
                            REG_CTRL: rd_mux = ctrl_rd[i];
                            REG_LO:   rd_mux = lo_rd[i];
                            REG_HI:   rd_mux = hi_rd[i];
                            default:  rd_mux = '0;
                        endcase
                    end
                end
            end
        endcase
    end

    // Storage is reset as well, since shadows and flags are software-visible.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            global_en     <= 1'b0;
            freeze_on_ovf <= 1'b0;
            ovf           <= '0;
            mask          <= '0;
            evt_q         <= '0;
            irq_o         <= 1'b0;
            cfg_rdata     <= '0;
            cfg_rvalid    <= 1'b0;
        end else begin
            evt_q <= evt_i;
            if (gctrl_we) begin
                global_en     <= cfg_wdata[GCTRL_EN_BIT];
                freeze_on_ovf <= cfg_wdata[GCTRL_FREEZE_BIT];
            end
            ovf        <= ovf_next;
            mask       <= mask_next;
            irq_o      <= |(ovf_next & mask_next);
            cfg_rvalid <= cfg_ren;
            if (cfg_ren)
                cfg_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench: directed scenarios plus random traffic, with reads scored
// against a behavioural model of the counter bank through a FIFO scoreboard.
module tb_perf_counter_bank;
    import perf_counter_bank_pkg::*;

    localparam int NUM_CNT   = 8;
    localparam int NUM_EVT   = 16;
    localparam int CNT_WIDTH = 48;
    localparam int SEL_W     = $clog2(NUM_EVT);
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_WIDTH) - 64'd1;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic [NUM_EVT-1:0] evt_i = '0;
    logic               cfg_wen = 1'b0;
    logic               cfg_ren = 1'b0;
    logic [7:0]         cfg_addr = '0;
    logic [31:0]        cfg_wdata = '0;
    logic [31:0]        cfg_rdata;
    logic               cfg_rvalid;
    logic               irq_o;

    perf_counter_bank #(
        .NUM_CNT   (NUM_CNT),
        .NUM_EVT   (NUM_EVT),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .evt_i      (evt_i),
        .cfg_wen    (cfg_wen),
        .cfg_ren    (cfg_ren),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .cfg_rvalid (cfg_rvalid),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint unsigned    m_cnt    [NUM_CNT];
    longint unsigned    m_shadow [NUM_CNT];
    int                 m_sel    [NUM_CNT];
    bit                 m_en     [NUM_CNT];
    bit                 m_edge   [NUM_CNT];
    bit                 m_gen, m_frz, m_irq, m_rvalid;
    bit [NUM_CNT-1:0]   m_ovf, m_mask;
    bit [NUM_EVT-1:0]   m_evt_q;

    typedef struct { logic [7:0] addr; logic [31:0] data; } exp_t;
    typedef struct { bit has; logic [31:0] data; string name; } dir_t;
    exp_t exp_q[$];
    dir_t dir_q[$];

    function automatic logic [7:0] a_ctrl(input int i); return 8'(16 + 4 * i); endfunction
    function automatic logic [7:0] a_lo(input int i);   return 8'(17 + 4 * i); endfunction
    function automatic logic [7:0] a_hi(input int i);   return 8'(18 + 4 * i); endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int i;
        if (a == 8'h00) return {30'd0, m_frz, m_gen};
        if (a == 8'h01) return 32'(m_ovf);
        if (a == 8'h02) return 32'(m_mask);
        if (a < 8'h10) return 32'd0;
        i = (int'(a) - 16) / 4;
        if (i >= NUM_CNT) return 32'd0;
        case (int'(a) % 4)
            0: return 32'(m_sel[i]) | (32'(m_en[i]) << 8) | (32'(m_edge[i]) << 9);
            1: return 32'(m_shadow[i]);
            2: return 32'(m_shadow[i] >> 32);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit frozen, snap, clr, cond;
        bit [NUM_CNT-1:0] new_ovf;
        if (!resetn) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                m_cnt[i] = 0; m_shadow[i] = 0; m_sel[i] = 0; m_en[i] = 0; m_edge[i] = 0;
            end
            m_gen = 0; m_frz = 0; m_irq = 0; m_rvalid = 0;
            m_ovf = '0; m_mask = '0; m_evt_q = '0;
        end else begin
            if (cfg_ren) exp_q.push_back('{cfg_addr, model_read(cfg_addr)});
            m_rvalid = cfg_ren;
            frozen  = m_frz && (m_ovf != 0);
            snap    = cfg_wen && cfg_addr == 8'h00 && cfg_wdata[2];
            clr     = cfg_wen && cfg_addr == 8'h00 && cfg_wdata[3];
            new_ovf = m_ovf;
            if (cfg_wen && cfg_addr == 8'h01) new_ovf = new_ovf & ~cfg_wdata[NUM_CNT-1:0];
            for (int i = 0; i < NUM_CNT; i++) begin
                if (snap) m_shadow[i] = m_cnt[i];
                cond = m_sel[i] < NUM_EVT && evt_i[m_sel[i]] && !(m_edge[i] && m_evt_q[m_sel[i]]);
                if (clr)
                    m_cnt[i] = 0;
                else if (cfg_wen && cfg_addr == a_lo(i))
                    m_cnt[i] = (m_cnt[i] & ~64'hFFFF_FFFF) | 64'(cfg_wdata);
                else if (cfg_wen && cfg_addr == a_hi(i))
                    m_cnt[i] = ((m_cnt[i] & 64'hFFFF_FFFF) | (64'(cfg_wdata) << 32)) & CNT_MAX;
                else if (m_gen && m_en[i] && !frozen && cond) begin
                    if (m_cnt[i] == CNT_MAX) begin
                        m_cnt[i] = 0;
                        new_ovf[i] = 1'b1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
                if (cfg_wen && cfg_addr == a_ctrl(i)) begin
                    m_sel[i]  = int'(cfg_wdata[SEL_W-1:0]);
                    m_en[i]   = cfg_wdata[8];
                    m_edge[i] = cfg_wdata[9];
                end
            end
            m_ovf = clr ? '0 : new_ovf;
            if (cfg_wen && cfg_addr == 8'h02) m_mask = cfg_wdata[NUM_CNT-1:0];
            if (cfg_wen && cfg_addr == 8'h00) begin
                m_gen = cfg_wdata[0];
                m_frz = cfg_wdata[1];
            end
            m_irq   = |(m_ovf & m_mask);
            m_evt_q = evt_i;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_on) begin
            check("rvalid", 64'(cfg_rvalid), 64'(m_rvalid));
            check("irq", 64'(irq_o), 64'(m_irq));
            if (cfg_rvalid) begin
                if (exp_q.size() == 0 || dir_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got rdata 0x%0h with no read pending", cfg_rdata);
                end else begin
                    exp_t e;
                    dir_t d;
                    e = exp_q.pop_front();
                    d = dir_q.pop_front();
                    check($sformatf("rdata_model@%02h", e.addr), 64'(cfg_rdata), 64'(e.data));
                    if (d.has) check(d.name, 64'(cfg_rdata), 64'(d.data));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cfg_wen = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_wen = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input string name, input logic [31:0] exp);
        cfg_ren = 1'b1; cfg_addr = a;
        dir_q.push_back('{1'b1, exp, name});
        @(negedge clk);
        cfg_ren = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_evt(input int b);
        evt_i[b] = 1'b1;
        @(negedge clk);
        evt_i[b] = 1'b0;
    endtask

    task automatic preload_max(input int i, input int sel);
        wr(a_ctrl(i), 32'(sel));
        wr(a_lo(i), 32'hFFFF_FFFF);
        wr(a_hi(i), 32'h0000_FFFF);
        wr(a_ctrl(i), 32'(sel) | 32'h100);
    endtask

    task automatic evt1_pattern();
        evt_i[EVT_LOAD] = 1'b1; idle(10);
        evt_i[EVT_LOAD] = 1'b0; idle(3);
        evt_i[EVT_LOAD] = 1'b1; idle(5);
        evt_i[EVT_LOAD] = 1'b0;
    endtask

    initial begin
        int r, k;
        logic [7:0]  a;
        logic [31:0] d;

        evt_i = 16'(1 << EVT_CYCLE);
        @(negedge clk); @(negedge clk);
        mon_on = 1'b1;
        @(negedge clk);
        resetn = 1'b1;

        rd(ADDR_GCTRL, "rst_gctrl", 0);
        rd(ADDR_OVF, "rst_ovf", 0);
        rd(ADDR_MASK, "rst_mask", 0);
        rd(a_ctrl(0), "rst_ctrl0", 0);
        rd(a_lo(3), "rst_lo3", 0);

        // level count of the cycle event
        wr(a_ctrl(0), 32'(EVT_CYCLE) | 32'h100);
        wr(ADDR_GCTRL, 32'h1);
        idle(100);
        wr(ADDR_GCTRL, 32'h5);
        rd(a_lo(0), "level_lo0", 100);
        rd(a_hi(0), "level_hi0", 0);

        // edge vs level on event 1
        wr(ADDR_GCTRL, 32'h8);
        wr(a_ctrl(1), 32'(EVT_LOAD) | 32'h300);
        wr(ADDR_GCTRL, 32'h1);
        evt1_pattern();
        wr(ADDR_GCTRL, 32'h5);
        rd(a_lo(1), "edge_cnt", 2);
        wr(ADDR_GCTRL, 32'h8);
        wr(a_ctrl(1), 32'(EVT_LOAD) | 32'h100);
        wr(ADDR_GCTRL, 32'h1);
        evt1_pattern();
        wr(ADDR_GCTRL, 32'h5);
        rd(a_lo(1), "level_cnt", 15);
        rd(a_ctrl(1), "ctrl1_rb", 32'h101);

        // wrap and irq
        wr(ADDR_GCTRL, 32'h8);
        wr(a_ctrl(1), 32'h0);
        preload_max(0, EVT_LOAD);
        wr(ADDR_MASK, 32'h1);
        wr(ADDR_GCTRL, 32'h1);
        pulse_evt(EVT_LOAD);
        check("irq_after_wrap", 64'(irq_o), 64'd1);
        rd(ADDR_OVF, "ovf_wrap", 1);
        wr(ADDR_GCTRL, 32'h5);
        rd(a_lo(0), "wrap_lo", 0);
        rd(a_hi(0), "wrap_hi", 0);
        wr(ADDR_OVF, 32'h1);
        check("irq_after_w1c", 64'(irq_o), 64'd0);

        // freeze on overflow
        wr(ADDR_GCTRL, 32'h8);
        preload_max(0, EVT_LOAD);
        wr(a_ctrl(2), 32'(EVT_CYCLE) | 32'h100);
        wr(ADDR_GCTRL, 32'h3);
        idle(9);
        pulse_evt(EVT_LOAD);
        idle(5);
        wr(ADDR_GCTRL, 32'h7);
        rd(a_lo(2), "frozen_cnt2", 10);
        wr(ADDR_OVF, 32'h1);
        idle(4);
        wr(ADDR_GCTRL, 32'h7);
        rd(a_lo(2), "resume_cnt2", 14);

        // LO write collides with an increment
        wr(ADDR_GCTRL, 32'h1);
        wr(a_lo(2), 32'h1234);
        wr(ADDR_GCTRL, 32'h5);
        rd(a_lo(2), "lo_write_wins", 32'h1234);
        rd(a_hi(2), "hi_untouched", 0);

        // clear_all with a pending overflow
        preload_max(0, EVT_LOAD);
        pulse_evt(EVT_LOAD);
        rd(ADDR_OVF, "ovf_pending", 1);
        wr(ADDR_GCTRL, 32'h8);
        wr(ADDR_GCTRL, 32'h4);
        rd(ADDR_OVF, "ovf_cleared", 0);
        rd(a_lo(0), "clr_lo0", 0);
        rd(a_lo(2), "clr_lo2", 0);
        check("irq_after_clear", 64'(irq_o), 64'd0);

        // W1C coinciding with a fresh overflow
        wr(ADDR_GCTRL, 32'h1);
        preload_max(0, EVT_LOAD);
        pulse_evt(EVT_LOAD);
        preload_max(0, EVT_LOAD);
        evt_i[EVT_LOAD] = 1'b1;
        wr(ADDR_OVF, 32'h1);
        evt_i[EVT_LOAD] = 1'b0;
        rd(ADDR_OVF, "ovf_set_beats_w1c", 1);
        check("irq_held", 64'(irq_o), 64'd1);

        // reset while counting
        evt_i = 16'($urandom);
        idle(3);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("rst_mid_rvalid", 64'(cfg_rvalid), 64'd0);
        check("rst_mid_irq", 64'(irq_o), 64'd0);
        rd(ADDR_GCTRL, "rst_mid_gctrl", 0);
        rd(ADDR_OVF, "rst_mid_ovf", 0);
        rd(ADDR_MASK, "rst_mid_mask", 0);
        rd(a_ctrl(0), "rst_mid_ctrl0", 0);
        rd(a_lo(0), "rst_mid_lo0", 0);
        rd(a_hi(0), "rst_mid_hi0", 0);
        rd(a_lo(2), "rst_mid_lo2", 0);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            evt_i   = NUM_EVT'($urandom);
            cfg_ren = ($urandom_range(0, 3) == 0);
            cfg_wen = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            k = $urandom_range(0, NUM_CNT - 1);
            d = $urandom;
            case (r)
                0: begin
                    a = ADDR_GCTRL;
                    d = 32'(($urandom_range(0, 7) != 0) ? 1 : 0)
                      | 32'(($urandom_range(0, 3) == 0) ? 2 : 0)
                      | 32'(($urandom_range(0, 1) == 0) ? 4 : 0)
                      | 32'(($urandom_range(0, 15) == 0) ? 8 : 0);
                end
                1: a = ADDR_OVF;
                2: a = ADDR_MASK;
                3, 4, 5: begin
                    a = a_ctrl(k);
                    d = d & 32'h0000_030F;
                end
                6, 7: begin
                    a = a_lo(k);
                    if ($urandom_range(0, 1) == 0) d = 32'hFFFF_FFF0 | (d & 32'hF);
                end
                8: begin
                    a = a_hi(k);
                    if ($urandom_range(0, 1) == 0) d = 32'h0000_FFFF;
                end
                default: a = 8'($urandom_range(0, 8'h4F));
            endcase
            cfg_addr  = a;
            cfg_wdata = d;
            if (cfg_ren) dir_q.push_back('{1'b0, 32'd0, ""});
            @(negedge clk);
        end
        cfg_wen = 1'b0;
        cfg_ren = 1'b0;

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
        if (exp_q.size() != 0 || dir_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d reads still pending, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
